// File: rtl/bh_key_pkg.sv
// Shared front-panel key definitions: key count, default debounce/repeat timing,
// channel state encoding and the key-bit to beep-tone mapping used by the beep generator.
package bh_key_pkg;

  localparam int NUM_KEYS = 8;
  localparam int CLK_HZ   = 5_000_000;

  localparam int DEB_CYC_DEF    = CLK_HZ / 50;  // 20 ms
  localparam int REPEAT_DLY_DEF = CLK_HZ / 2;   // 0.5 s
  localparam int REPEAT_PER_DEF = CLK_HZ / 5;   // 0.2 s

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    HELD  = 2'd2,
    RWAIT = 2'd3
  } ch_state_t;

  localparam int KEY_TEMP_UP = 0;
  localparam int KEY_TEMP_DN = 1;
  localparam int KEY_POWER   = 2;
  localparam int KEY_MODE    = 3;
  localparam int KEY_FAN     = 4;
  localparam int KEY_LIGHT   = 5;
  localparam int KEY_TIMER   = 6;
  localparam int KEY_DRY     = 7;

  typedef enum logic [1:0] {
    TONE_NONE  = 2'd0,
    TONE_SHORT = 2'd1,
    TONE_HIGH  = 2'd2,
    TONE_LONG  = 2'd3
  } tone_t;

  function automatic tone_t key_tone(input logic [NUM_KEYS-1:0] key);
    tone_t t;
    t = TONE_NONE;
    if (key[KEY_POWER]) t = TONE_LONG;
    else if (key[KEY_TEMP_UP] || key[KEY_TEMP_DN]) t = TONE_HIGH;
    else if (|key) t = TONE_SHORT;
    return t;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and optional auto-repeat.
// evt is a registered one-cycle pulse on accepted press and on each repeat.
module key_debounce_ch
  import bh_key_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic evt,
  output logic level
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYC - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DLY - 1);
  // Reloading to DLY-PER makes the next hit of REP_LAST land REPEAT_PER cycles later.
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);

  logic          sync1;
  logic          sync2;
  logic          s;
  ch_state_t     state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REL;
      cnt   <= '0;
      rep   <= '0;
      evt   <= 1'b0;
    end else begin
      evt <= 1'b0;
      unique case (state)
        REL: begin
          if (s) begin
            state <= PWAIT;
            cnt   <= '0;
          end
        end
        PWAIT: begin
          if (!s) begin
            state <= REL;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            evt   <= 1'b1;
            rep   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RWAIT;
            cnt   <= '0;
          end else if (REPEAT_EN) begin
            if (rep == REP_LAST) begin
              evt <= 1'b1;
              rep <= REP_RELOAD;
            end else begin
              rep <= rep + 1'b1;
            end
          end
        end
        RWAIT: begin
          // A short release glitch returns to HELD with rep untouched.
          if (s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= REL;
      endcase
    end
  end

  assign level = (state == HELD) || (state == RWAIT);

endmodule

// File: rtl/key_scan.sv
// Front-panel key scanner: 8 debounced channels, highest-index-wins one-hot press strobe.
// Strobe appears DEB_CYC+3 edges after the first low sample; no backpressure, strobes are not queued.
module key_scan
  import bh_key_pkg::*;
#(
  parameter int                  DEB_CYC     = DEB_CYC_DEF,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = '0,
  parameter int                  REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int                  REPEAT_PER  = REPEAT_PER_DEF
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] btn_n,
  output logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                key_any
);

  logic [NUM_KEYS-1:0] evt;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] key_nxt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYC   (DEB_CYC),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER),
      .REPEAT_EN (REPEAT_MASK[i])
    ) u_ch (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .btn_n  (btn_n[i]),
      .evt    (evt[i]),
      .level  (level[i])
    );
  end

  // Later iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    key_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (evt[i]) begin
        key_nxt    = '0;
        key_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= '0;
      key_level <= '0;
      key_any   <= 1'b0;
    end else begin
      key       <= key_nxt;
      key_level <= level;
      key_any   <= |level;
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: directed scenarios plus random button traffic, checked every cycle
// against a run-length model of the debounce and repeat rules.
module tb_key_scan;

  localparam int         DEB  = 16;
  localparam int         DLY  = 64;
  localparam int         PER  = 32;
  localparam logic [7:0] MASK = 8'h01;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] btn_n   = 8'hff;
  logic [7:0] key;
  logic [7:0] key_level;
  logic       key_any;

  key_scan #(
    .DEB_CYC    (DEB),
    .REPEAT_MASK(MASK),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .btn_n    (btn_n),
    .key      (key),
    .key_level(key_level),
    .key_any  (key_any)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int base   = 0;

  // Reference model: accepted level per key, length of the current disagreeing run,
  // and count of steadily-held samples since the press was accepted.
  bit         acc[8];
  int         run_len[8];
  int         ticks[8];
  logic [7:0] pk[3];
  logic [7:0] pl[3];
  logic [7:0] exp_key;
  logic [7:0] exp_lvl;

  int         st_edge[$];
  logic [7:0] st_val[$];
  logic [7:0] st_lvl[$];
  int         ex[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      acc[i]     = 1'b0;
      run_len[i] = 0;
      ticks[i]   = 0;
    end
    for (int k = 0; k < 3; k++) begin
      pk[k] = '0;
      pl[k] = '0;
    end
    exp_key = '0;
    exp_lvl = '0;
  endtask

  // A key's accepted state flips once the raw sample has disagreed with it for
  // DEB+1 consecutive edges; its effect reaches the outputs 3 edges after that sample.
  task automatic model_sample(input logic [7:0] b);
    logic [7:0] ev;
    logic [7:0] oh;
    logic [7:0] lv;
    bit         p;
    ev = '0;
    oh = '0;
    lv = '0;
    for (int i = 0; i < 8; i++) begin
      p = ~b[i];
      if (p != acc[i]) begin
        run_len[i]++;
        if (run_len[i] == DEB + 1) begin
          acc[i]     = p;
          run_len[i] = 0;
          if (p) begin
            ev[i]    = 1'b1;
            ticks[i] = 0;
          end
        end
      end else begin
        if (acc[i] && run_len[i] == 0 && MASK[i]) begin
          ticks[i]++;
          if (ticks[i] == DLY || (ticks[i] > DLY && (ticks[i] - DLY) % PER == 0))
            ev[i] = 1'b1;
        end
        run_len[i] = 0;
      end
      lv[i] = acc[i];
    end
    for (int i = 0; i < 8; i++)
      if (ev[i]) oh = 8'h01 << i;
    exp_key = pk[2];
    exp_lvl = pl[2];
    pk[2] = pk[1]; pl[2] = pl[1];
    pk[1] = pk[0]; pl[1] = pl[0];
    pk[0] = oh;    pl[0] = lv;
  endtask

  // Called at a negedge: drive, let one posedge sample it, compare at the next negedge.
  task automatic step(input logic [7:0] b);
    btn_n = b;
    @(posedge sys_clk);
    cyc++;
    model_sample(b);
    @(negedge sys_clk);
    chk("key", 32'(key), 32'(exp_key));
    chk("key_level", 32'(key_level), 32'(exp_lvl));
    chk("key_any", 32'(key_any), 32'(|exp_lvl));
    if (key != 8'h00) begin
      st_edge.push_back(cyc - base - 1);
      st_val.push_back(key);
      st_lvl.push_back(key_level);
    end
  endtask

  task automatic hold(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) step(b);
  endtask

  task automatic mark();
    base = cyc;
    st_edge.delete();
    st_val.delete();
    st_lvl.delete();
    ex.delete();
  endtask

  task automatic chk_strobes(input string tag, input logic [7:0] val);
    chk({tag, "_count"}, 32'(st_edge.size()), 32'(ex.size()));
    for (int k = 0; k < ex.size() && k < st_edge.size(); k++) begin
      chk({tag, "_edge"}, 32'(st_edge[k]), 32'(ex[k]));
      chk({tag, "_val"}, 32'(st_val[k]), 32'(val));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_key", 32'(key), 32'h0);
    chk("rst_level", 32'(key_level), 32'h0);
    chk("rst_any", 32'(key_any), 32'h0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cur;
    int         rem[8];

    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("init_key", 32'(key), 32'h0);
    chk("init_level", 32'(key_level), 32'h0);
    chk("init_any", 32'(key_any), 32'h0);
    rst_n = 1'b1;
    hold(8'hff, 5);

    // clean press on key 7
    mark();
    hold(8'h7f, 100);
    ex.push_back(19);
    chk_strobes("clean", 8'h80);
    if (st_lvl.size() > 0) chk("clean_lvl", 32'(st_lvl[0]), 32'h80);
    hold(8'hff, 30);

    // bouncing key 3, final low starts at edge 20
    mark();
    hold(8'hf7, 5); hold(8'hff, 5); hold(8'hf7, 5); hold(8'hff, 5);
    hold(8'hf7, 60);
    ex.push_back(39);
    chk_strobes("bounce", 8'h08);
    hold(8'hff, 30);

    // simultaneous keys 2 and 5
    mark();
    hold(8'hdb, 60);
    ex.push_back(19);
    chk_strobes("simul", 8'h20);
    if (st_lvl.size() > 0) chk("simul_lvl", 32'(st_lvl[0]), 32'h24);
    hold(8'hff, 30);

    // auto-repeat on key 0
    mark();
    hold(8'hfe, 250);
    ex.push_back(19);
    for (int t = 19 + DLY; t < 250; t += PER) ex.push_back(t);
    chk_strobes("repeat", 8'h01);
    hold(8'hff, 30);

    // key 1 has no repeat
    mark();
    hold(8'hfd, 250);
    ex.push_back(19);
    chk_strobes("norepeat", 8'h02);
    hold(8'hff, 30);

    // release glitch on key 0: nine held samples lost, repeat shifts by nine
    mark();
    hold(8'hfe, 100);
    hold(8'hff, 8);
    hold(8'hfe, 100);
    ex.push_back(19); ex.push_back(83); ex.push_back(124);
    ex.push_back(156); ex.push_back(188);
    chk_strobes("glitch", 8'h01);
    chk("glitch_lvl", 32'(key_level), 32'h01);

    // reset while held; button kept down through release counts as a new press
    do_reset();
    mark();
    hold(8'hfe, 30);
    ex.push_back(19);
    chk_strobes("held_rst", 8'h01);
    hold(8'hff, 30);

    // reset in the middle of the debounce window
    mark();
    hold(8'hef, 10);
    chk_strobes("pwait_pre", 8'h10);
    do_reset();
    mark();
    hold(8'hef, 40);
    ex.push_back(19);
    chk_strobes("pwait_rst", 8'h10);
    hold(8'hff, 30);

    // random traffic
    cur = 8'hff;
    for (int i = 0; i < 8; i++) rem[i] = $urandom_range(1, 50);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          case ($urandom_range(0, 5))
            0, 1:    rem[i] = $urandom_range(1, 6);
            2:       rem[i] = $urandom_range(12, 22);
            3:       rem[i] = $urandom_range(150, 300);
            default: rem[i] = $urandom_range(23, 120);
          endcase
        end
        rem[i]--;
      end
      step(cur);
    end
    hold(8'hff, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
